// File: rtl/mem_arbiter_if.sv
// Requester-side bundle for mem_arbiter: fetch and MEM-stage handshakes plus stall requests.
// The pipeline uses the master modport; the arbiter uses the slave modport.
interface mem_arbiter_if;
    logic        if_req;
    logic        if_cancel;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;

    logic        mem_load;
    logic        mem_store;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_length;
    logic        mem_signed;
    logic        mem_done;
    logic [31:0] mem_rdata;

    logic        stall_if;
    logic        stall_mem;

    modport master (
        output if_req, if_cancel, if_addr, mem_load, mem_store, mem_addr,
               mem_wdata, mem_length, mem_signed,
        input  if_done, if_data, mem_done, mem_rdata, stall_if, stall_mem
    );

    modport slave (
        input  if_req, if_cancel, if_addr, mem_load, mem_store, mem_addr,
               mem_wdata, mem_length, mem_signed,
        output if_done, if_data, mem_done, mem_rdata, stall_if, stall_mem
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide synchronous RAM port between instruction fetch and the MEM stage,
// sequencing multi-byte accesses one byte per cycle and assembling/extending load data.
module mem_arbiter #(
    parameter int ADDR_W = 17
) (
    input  logic              clock,
    input  logic              reset,
    mem_arbiter_if.slave      bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);
    typedef enum logic [1:0] {IDLE, ISSUE, TAIL, DONE} state_t;

    state_t      state;
    logic        owner_mem;
    logic        op_store;
    logic        op_signed;
    logic [2:0]  len;
    logic [2:0]  cnt;
    logic [23:0] wbuf;
    logic [23:0] rbuf;
    logic [31:0] assembled;
    logic [31:0] extended;
    logic        unused_addr_bits;

    function automatic logic [2:0] decode_len(input logic [2:0] l);
        case (l)
            3'd1:    decode_len = 3'd1;
            3'd2:    decode_len = 3'd2;
            default: decode_len = 3'd4;
        endcase
    endfunction

    assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W], bus.mem_addr[31:ADDR_W]};

    assign bus.stall_if  = bus.if_req & ~bus.if_done;
    assign bus.stall_mem = (bus.mem_load | bus.mem_store) & ~bus.mem_done;

    // Read bytes arrive LSB first and are shifted in from the top, so the last
    // L bytes received always sit in the upper L byte lanes of 'assembled'.
    always_comb begin
        assembled = {ram_din, rbuf};
        extended  = assembled;
        case (len)
            3'd1:    extended = {{24{op_signed & assembled[31]}}, assembled[31:24]};
            3'd2:    extended = {{16{op_signed & assembled[31]}}, assembled[31:16]};
            default: extended = assembled;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            owner_mem     <= 1'b0;
            op_store      <= 1'b0;
            op_signed     <= 1'b0;
            len           <= 3'd4;
            cnt           <= 3'd0;
            wbuf          <= 24'h0;
            rbuf          <= 24'h0;
            ram_addr      <= '0;
            ram_wr        <= 1'b0;
            ram_dout      <= 8'h00;
            bus.if_done   <= 1'b0;
            bus.if_data   <= 32'h0;
            bus.mem_done  <= 1'b0;
            bus.mem_rdata <= 32'h0;
        end else begin
            bus.if_done  <= 1'b0;
            bus.mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    ram_wr <= 1'b0;
                    cnt    <= 3'd0;
                    rbuf   <= 24'h0;
                    if (bus.mem_load | bus.mem_store) begin
                        owner_mem <= 1'b1;
                        op_store  <= bus.mem_store;
                        op_signed <= bus.mem_signed;
                        len       <= decode_len(bus.mem_length);
                        ram_addr  <= bus.mem_addr[ADDR_W-1:0];
                        ram_wr    <= bus.mem_store;
                        ram_dout  <= bus.mem_wdata[7:0];
                        wbuf      <= bus.mem_wdata[31:8];
                        state     <= ISSUE;
                    end else if (bus.if_req & ~bus.if_cancel) begin
                        owner_mem <= 1'b0;
                        op_store  <= 1'b0;
                        op_signed <= 1'b0;
                        len       <= 3'd4;
                        ram_addr  <= bus.if_addr[ADDR_W-1:0];
                        wbuf      <= 24'h0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!owner_mem && bus.if_cancel) begin
                        state <= IDLE;
                    end else begin
                        if (cnt != 3'd0 && !op_store)
                            rbuf <= {ram_din, rbuf[23:8]};
                        if (cnt == len - 3'd1) begin
                            ram_wr <= 1'b0;
                            if (op_store) begin
                                bus.mem_done <= 1'b1;
                                state        <= DONE;
                            end else begin
                                state <= TAIL;
                            end
                        end else begin
                            ram_addr <= ram_addr + ADDR_W'(1);
                            ram_dout <= wbuf[7:0];
                            wbuf     <= {8'h00, wbuf[23:8]};
                            ram_wr   <= op_store;
                            cnt      <= cnt + 3'd1;
                        end
                    end
                end
                TAIL: begin
                    if (!owner_mem && bus.if_cancel) begin
                        state <= IDLE;
                    end else begin
                        if (owner_mem) begin
                            bus.mem_done  <= 1'b1;
                            bus.mem_rdata <= extended;
                        end else begin
                            bus.if_done <= 1'b1;
                            bus.if_data <= assembled;
                        end
                        state <= DONE;
                    end
                end
                // A request still held during the done pulse is not re-accepted here.
                DONE: begin
                    ram_wr <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random transactions
// checked against a byte-array memory model and arithmetic load extension.
module tb_mem_arbiter;
    localparam int ADDR_W = 17;
    localparam int MEM_SZ = 1 << ADDR_W;

    logic              clock;
    logic              reset;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;

    logic              bd_we;
    logic [ADDR_W-1:0] bd_addr;
    logic [7:0]        bd_data;

    logic [7:0] ram       [0:MEM_SZ-1];
    logic [7:0] model_mem [0:MEM_SZ-1];

    int checks = 0;
    int errors = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_wr   (ram_wr),
        .ram_dout (ram_dout),
        .ram_din  (ram_din)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Synchronous RAM with a backdoor write port used only to preload contents.
    always @(posedge clock) begin
        if (bd_we)
            ram[bd_addr] <= bd_data;
        else if (ram_wr)
            ram[ram_addr] <= ram_dout;
        ram_din <= ram[ram_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // kind: 0 fetch, 1 load, 2 store, anything else drops all requests
    task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [2:0] length,
                                 input logic sgn, input logic [31:0] wdata);
        bus.if_req     = (kind == 0);
        bus.if_cancel  = 1'b0;
        bus.if_addr    = addr;
        bus.mem_load   = (kind == 1);
        bus.mem_store  = (kind == 2);
        bus.mem_addr   = addr;
        bus.mem_wdata  = wdata;
        bus.mem_length = length;
        bus.mem_signed = sgn;
    endtask

    task automatic bd_write(input int addr, input logic [7:0] data);
        model_mem[addr] = data;
        bd_we   = 1'b1;
        bd_addr = ADDR_W'(addr);
        bd_data = data;
        @(posedge clock); #1;
        bd_we = 1'b0;
    endtask

    function automatic int model_len(input int kind, input logic [2:0] length);
        if (kind == 0) return 4;
        if (length == 3'd1) return 1;
        if (length == 3'd2) return 2;
        return 4;
    endfunction

    function automatic int wrap_idx(input logic [31:0] addr, input int i);
        logic [31:0] a;
        a = (addr + 32'(i)) & 32'(MEM_SZ - 1);
        return int'(a);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr, input int n, input logic sgn);
        longint v;
        v = 0;
        for (int i = 0; i < n; i++)
            v = v + (longint'(model_mem[wrap_idx(addr, i)]) << (8 * i));
        if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    function automatic logic [31:0] ram_read(input logic [31:0] addr, input int n);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < n; i++)
            v = v | (32'(ram[wrap_idx(addr, i)]) << (8 * i));
        return v;
    endfunction

    task automatic run_txn(input int kind, input logic [31:0] addr, input logic [2:0] length,
                           input logic sgn, input logic [31:0] wdata, input string tag,
                           output logic [31:0] obs);
        int          n;
        int          exp_lat;
        int          cycles;
        int          wr_cnt;
        logic        done_seen;
        logic        stall_first;
        logic        stall_done;
        logic [31:0] exp_data;
        logic [31:0] wtmp;

        n        = model_len(kind, length);
        exp_lat  = (kind == 2) ? n + 1 : n + 2;
        exp_data = model_read(addr, n, (kind == 1) ? sgn : 1'b0);
        applyStimulus(kind, addr, length, sgn, wdata);
        cycles = 0; wr_cnt = 0; done_seen = 1'b0; stall_first = 1'b0;
        while (!done_seen && cycles < 20) begin
            @(posedge clock); #1;
            cycles++;
            if (ram_wr) wr_cnt++;
            if (cycles == 1) stall_first = (kind == 0) ? bus.stall_if : bus.stall_mem;
            done_seen = (kind == 0) ? bus.if_done : bus.mem_done;
        end
        stall_done = (kind == 0) ? bus.stall_if : bus.stall_mem;
        obs = (kind == 0) ? bus.if_data : bus.mem_rdata;
        checkOutput({tag, "_stall_busy"}, 32'(stall_first), 32'd1);
        checkOutput({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
        checkOutput({tag, "_stall_done"}, 32'(stall_done), 32'd0);
        checkOutput({tag, "_wr_count"}, 32'(wr_cnt), (kind == 2) ? 32'(n) : 32'd0);
        if (kind != 2)
            checkOutput({tag, "_data"}, obs, exp_data);
        applyStimulus(3, 32'h0, 3'd0, 1'b0, 32'h0);
        @(posedge clock); #1;
        checkOutput({tag, "_pulse"}, (kind == 0) ? 32'(bus.if_done) : 32'(bus.mem_done), 32'd0);
        if (kind == 2) begin
            for (int i = 0; i < n; i++) begin
                wtmp = wdata >> (8 * i);
                model_mem[wrap_idx(addr, i)] = wtmp[7:0];
            end
            checkOutput({tag, "_ram"}, ram_read(addr, n), model_read(addr, n, 1'b0));
        end
    endtask

    initial begin
        logic [31:0] obs;
        logic [31:0] addr;
        logic [31:0] upper;
        logic [7:0]  orig [0:3];
        int          cycles;
        logic        early;

        reset = 1'b1;
        bd_we = 1'b0; bd_addr = '0; bd_data = 8'h00;
        applyStimulus(3, 32'h0, 3'd0, 1'b0, 32'h0);
        repeat (2) @(posedge clock);
        #1;

        for (int a = 32'h1000; a < 32'h1100; a++) bd_write(a, 8'($urandom()));
        for (int a = MEM_SZ - 8; a < MEM_SZ; a++) bd_write(a, 8'($urandom()));
        for (int a = 0; a < 8; a++) bd_write(a, 8'($urandom()));
        for (int a = 32'h20; a < 32'h24; a++) bd_write(a, 8'($urandom()));
        for (int a = 32'h40; a < 32'h48; a++) bd_write(a, 8'($urandom()));
        for (int a = 32'h60; a < 32'h64; a++) bd_write(a, 8'($urandom()));
        bd_write(32'h1000, 8'h13); bd_write(32'h1001, 8'h05);
        bd_write(32'h1002, 8'h00); bd_write(32'h1003, 8'h00);
        bd_write(32'h20, 8'h80);

        reset = 1'b0;
        checkOutput("rst_if_done", 32'(bus.if_done), 32'd0);
        checkOutput("rst_mem_done", 32'(bus.mem_done), 32'd0);
        checkOutput("rst_ram_wr", 32'(ram_wr), 32'd0);
        checkOutput("rst_ram_addr", 32'(ram_addr), 32'd0);
        checkOutput("rst_ram_dout", 32'(ram_dout), 32'd0);
        checkOutput("rst_if_data", bus.if_data, 32'd0);
        checkOutput("rst_mem_rdata", bus.mem_rdata, 32'd0);

        run_txn(0, 32'h1000, 3'd0, 1'b0, 32'h0, "t1_fetch", obs);
        checkOutput("t1_word", obs, 32'h00000513);

        run_txn(1, 32'h20, 3'd1, 1'b1, 32'h0, "t2_lb", obs);
        checkOutput("t2_sext", obs, 32'hFFFFFF80);
        run_txn(1, 32'h20, 3'd1, 1'b0, 32'h0, "t2_lbu", obs);
        checkOutput("t2_zext", obs, 32'h00000080);

        run_txn(2, 32'h40, 3'd4, 1'b0, 32'hDEADBEEF, "t3_sw", obs);
        checkOutput("t3_bytes", {ram[32'h43], ram[32'h42], ram[32'h41], ram[32'h40]}, 32'hDEADBEEF);

        // Simultaneous fetch and load: the load goes first, the fetch waits.
        applyStimulus(1, 32'h20, 3'd1, 1'b0, 32'h0);
        bus.if_req = 1'b1; bus.if_addr = 32'h1000;
        cycles = 0; early = 1'b0;
        while (!bus.mem_done && cycles < 20) begin
            @(posedge clock); #1; cycles++;
            if (bus.if_done) early = 1'b1;
        end
        checkOutput("t4_mem_first", 32'(cycles), 32'd3);
        checkOutput("t4_if_waits", 32'(early), 32'd0);
        bus.mem_load = 1'b0;
        while (!bus.if_done && cycles < 40) begin
            @(posedge clock); #1; cycles++;
        end
        checkOutput("t4_if_latency", 32'(cycles), 32'd10);
        checkOutput("t4_if_data", bus.if_data, 32'h00000513);
        applyStimulus(3, 32'h0, 3'd0, 1'b0, 32'h0);
        @(posedge clock); #1;

        // Cancel a fetch two cycles in, then redirect to a new address.
        applyStimulus(0, 32'h1000, 3'd0, 1'b0, 32'h0);
        cycles = 0; early = 1'b0;
        @(posedge clock); #1; cycles++; if (bus.if_done) early = 1'b1;
        @(posedge clock); #1; cycles++; if (bus.if_done) early = 1'b1;
        bus.if_cancel = 1'b1;
        @(posedge clock); #1; cycles++; if (bus.if_done) early = 1'b1;
        bus.if_cancel = 1'b0; bus.if_addr = 32'h1004;
        while (!bus.if_done && cycles < 30) begin
            @(posedge clock); #1; cycles++;
            if (ram_wr) early = 1'b1;
        end
        checkOutput("t5_no_done", 32'(early), 32'd0);
        checkOutput("t5_latency", 32'(cycles), 32'd9);
        checkOutput("t5_data", bus.if_data, model_read(32'h1004, 4, 1'b0));
        applyStimulus(3, 32'h0, 3'd0, 1'b0, 32'h0);
        @(posedge clock); #1;

        // Reset lands on the edge after the first store byte is presented.
        for (int i = 0; i < 4; i++) orig[i] = model_mem[32'h60 + i];
        applyStimulus(2, 32'h60, 3'd4, 1'b0, 32'h11223344);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        checkOutput("t6_wr_off", 32'(ram_wr), 32'd0);
        checkOutput("t6_mem_done", 32'(bus.mem_done), 32'd0);
        checkOutput("t6_rdata_clr", bus.mem_rdata, 32'd0);
        checkOutput("t6_ifdata_clr", bus.if_data, 32'd0);
        reset = 1'b0;
        applyStimulus(3, 32'h0, 3'd0, 1'b0, 32'h0);
        @(posedge clock); #1;
        checkOutput("t6_ram", ram_read(32'h60, 4), {orig[3], orig[2], orig[1], 8'h44});
        model_mem[32'h60] = 8'h44;
        run_txn(1, 32'h60, 3'd1, 1'b0, 32'h0, "t6_after", obs);

        run_txn(1, 32'hABC1FFFE, 3'd0, 1'b0, 32'h0, "wrap_lw", obs);
        run_txn(1, 32'h7771FFFF, 3'd2, 1'b1, 32'h0, "wrap_lh", obs);

        for (int t = 0; t < 40; t++) begin
            int kind;
            kind  = int'($urandom_range(0, 2));
            upper = $urandom() & 32'hFFFE0000;
            if ($urandom_range(0, 1) == 0)
                addr = 32'h1000 + 32'($urandom_range(0, 252));
            else
                addr = (32'(MEM_SZ - 4) + 32'($urandom_range(0, 7))) & 32'(MEM_SZ - 1);
            run_txn(kind, upper | addr, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    $urandom(), $sformatf("rnd%0d", t), obs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
